// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Byte FIFO between the UART receiver (or ALU result) and its consumer.
// It is first-word-fall-through: o_r_data always shows the head entry.
// The full and empty flags are registered and come from a next-pointer compare,
// so there is no separate count register.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   When it is defined, the block adds the sticky o_overflow and o_underflow
//   flags, which clear only on i_reset.
//
// Ports
//   clk          system clock, rising edge
//   i_reset      asynchronous, active-high reset
//   i_wr         push request, one byte per cycle
//   i_w_data     byte to push
//   i_rd         pop request, one byte per cycle
//   o_r_data     head-of-queue byte, valid while ~o_empty
//   o_empty      no bytes stored
//   o_full       2**W bytes stored
//   o_overflow   [FIFO_ERR_FLAGS_EN] sticky: push seen while full without pop
//   o_underflow  [FIFO_ERR_FLAGS_EN] sticky: pop seen while empty
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned B = 8,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_wr,
    input  logic [B-1:0] i_w_data,
    input  logic         i_rd,
    output logic [B-1:0] o_r_data,
    output logic         o_empty,
    output logic         o_full
`ifdef FIFO_ERR_FLAGS_EN
   ,output logic         o_overflow,
    output logic         o_underflow
`endif
);

    localparam int unsigned DEPTH = 1 << W;

    logic [B-1:0] mem_q [DEPTH];
    logic [W-1:0] wp_q, wp_d;
    logic [W-1:0] rp_q, rp_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         wr_en, rd_en;
    logic [W-1:0] wp_succ, rp_succ;

    assign wp_succ = wp_q + W'(1);
    assign rp_succ = rp_q + W'(1);

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    // A pop from an empty FIFO is always ignored.
    assign wr_en = i_wr & (~full_q | i_rd);
    assign rd_en = i_rd & ~empty_q;

    // Next-state logic for the pointers and flags.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        empty_d = empty_q;
        full_d  = full_q;
        if (wr_en) wp_d = wp_succ;
        if (rd_en) rp_d = rp_succ;
        unique case ({wr_en, rd_en})
            2'b10: begin
                empty_d = 1'b0;
                full_d  = (wp_succ == rp_q);
            end
            2'b01: begin
                full_d  = 1'b0;
                empty_d = (rp_succ == wp_q);
            end
            default: ;  // idle, or a simultaneous push and pop: the count does not change
        endcase
    end

    // State registers for the pointers and flags.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // Storage array. Its contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wp_q] <= i_w_data;
    end

    assign o_r_data = mem_q[rp_q];
    assign o_empty  = empty_q;
    assign o_full   = full_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags. Once set, they stay set until i_reset.
    always_comb begin
        overflow_d  = overflow_q | (i_wr & full_q & ~i_rd);
        underflow_d = underflow_q | (i_rd & empty_q);
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Scoreboard bench for uart_rx_fifo with B=8 and W=2.
// Each accepted push appends its byte to a reference queue.
// Each accepted pop takes the front of that queue and compares it with o_r_data.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_wr;
    logic [7:0] i_w_data;
    logic       i_rd;
    logic [7:0] o_r_data;
    logic       o_empty;
    logic       o_full;
`ifdef FIFO_ERR_FLAGS_EN
    logic       o_overflow;
    logic       o_underflow;
    logic       ovf_m;
    logic       udf_m;
`endif

    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.B(8), .W(2)) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_wr       (i_wr),
        .i_w_data   (i_w_data),
        .i_rd       (i_rd),
        .o_r_data   (o_r_data),
        .o_empty    (o_empty),
        .o_full     (o_full)
`ifdef FIFO_ERR_FLAGS_EN
       ,.o_overflow (o_overflow),
        .o_underflow(o_underflow)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Compares the status flags, and the head byte when the queue is not empty.
    task automatic check_state(input string tag);
        check_eq({tag, ".empty"}, 32'(o_empty), 32'(exp_q.size() == 0));
        check_eq({tag, ".full"},  32'(o_full),  32'(exp_q.size() == DEPTH));
        if (exp_q.size() != 0) check_eq({tag, ".head"}, 32'(o_r_data), 32'(exp_q[0]));
`ifdef FIFO_ERR_FLAGS_EN
        check_eq({tag, ".ovf"}, 32'(o_overflow),  32'(ovf_m));
        check_eq({tag, ".udf"}, 32'(o_underflow), 32'(udf_m));
`endif
    endtask

    // Runs one clock cycle with the given {wr, rd, data}.
    // Inputs change on the falling edge and outputs are checked 1 ns after the rising edge.
    task automatic cycle(input string tag, input logic wr, input logic rd, input logic [7:0] d);
        bit do_pop, do_push;
        @(negedge clk);
        i_wr = wr; i_rd = rd; i_w_data = d;
        do_pop  = rd && (exp_q.size() != 0);
        do_push = wr && ((exp_q.size() < DEPTH) || rd);
`ifdef FIFO_ERR_FLAGS_EN
        if (wr && (exp_q.size() == DEPTH) && !rd) ovf_m = 1'b1;
        if (rd && (exp_q.size() == 0)) udf_m = 1'b1;
`endif
        // The consumer samples the show-ahead byte in the same cycle it raises i_rd.
        if (do_pop) check_eq({tag, ".pop"}, 32'(o_r_data), 32'(exp_q.pop_front()));
        if (do_push) exp_q.push_back(d);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic idle();
        @(negedge clk);
        i_wr = 1'b0; i_rd = 1'b0;
    endtask

    // Asserts reset in the middle of a cycle.
    // The flags must respond at once, without waiting for a clock edge.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #3;
        i_wr = 1'b0; i_rd = 1'b0;
        i_reset = 1'b1;
        #1;
        exp_q.delete();
`ifdef FIFO_ERR_FLAGS_EN
        ovf_m = 1'b0; udf_m = 1'b0;
`endif
        check_state(tag);
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_wr = 1'b0; i_rd = 1'b0; i_w_data = 8'h00;
`ifdef FIFO_ERR_FLAGS_EN
        ovf_m = 1'b0; udf_m = 1'b0;
`endif
        #12;
        check_state("reset");
        @(negedge clk);
        i_reset = 1'b0;

        // T1: push three bytes, then pop them in order.
        cycle("t1.push", 1'b1, 1'b0, 8'h05);
        cycle("t1.push", 1'b1, 1'b0, 8'h03);
        cycle("t1.push", 1'b1, 1'b0, 8'h20);
        repeat (3) cycle("t1.pop", 1'b0, 1'b1, 8'h00);

        // T2: fill the FIFO, push once more while full (dropped), drain, then pop while empty.
        for (int i = 0; i < 4; i++) cycle("t2.push", 1'b1, 1'b0, 8'(8'h11 + i));
        cycle("t2.ovf", 1'b1, 1'b0, 8'h99);
        repeat (4) cycle("t2.pop", 1'b0, 1'b1, 8'h00);
        cycle("t2.udf", 1'b0, 1'b1, 8'h00);

        // T3: push and pop together while empty; only the push happens.
        cycle("t3.both", 1'b1, 1'b1, 8'hAA);
        cycle("t3.pop", 1'b0, 1'b1, 8'h00);

        // T4: push and pop together while full; the FIFO stays full.
        for (int i = 1; i <= 4; i++) cycle("t4.push", 1'b1, 1'b0, 8'(i));
        cycle("t4.both", 1'b1, 1'b1, 8'h55);
        repeat (4) cycle("t4.pop", 1'b0, 1'b1, 8'h00);

        // T5: ten push/pop pairs, so the pointers wrap more than once.
        for (int i = 0; i < 10; i++) begin
            cycle("t5.push", 1'b1, 1'b0, 8'(i));
            cycle("t5.pop",  1'b0, 1'b1, 8'h00);
        end

        // T6: asynchronous reset with three bytes stored, then a push after reset.
        for (int i = 0; i < 3; i++) cycle("t6.fill", 1'b1, 1'b0, 8'(8'hC0 + i));
        mid_reset("t6.rst");
        cycle("t6.push", 1'b1, 1'b0, 8'h7E);
        cycle("t6.pop",  1'b0, 1'b1, 8'h00);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            cycle("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        while (exp_q.size() != 0) cycle("drain", 1'b0, 1'b1, 8'h00);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
